// File: rtl/seq_reco_multi_if.sv
// Bundle of control, stream and status signals for seq_reco_multi.
// master drives the input streams; slave is the recorrelator itself.
interface seq_reco_multi_if #(
    parameter int unsigned NCH = 2
) ();
    logic           clr;
    logic           mode;
    logic           in_valid;
    logic           flush;
    logic [NCH-1:0] x;
    logic [NCH-1:0] y;
    logic           out_valid;
    logic [NCH-1:0] x_reco_r;
    logic [NCH-1:0] y_reco_r;
    logic           idle;

    modport master (
        output clr, mode, in_valid, flush, x, y,
        input  out_valid, x_reco_r, y_reco_r, idle
    );

    modport slave (
        input  clr, mode, in_valid, flush, x, y,
        output out_valid, x_reco_r, y_reco_r, idle
    );
endinterface

// File: rtl/seq_reco_multi.sv
// Multi-lane sequential recorrelator: each lane holds up to DEPTH unpaired 1s in a signed
// counter and re-emits them later, pushing stream correlation toward +1 (SYNC) or -1 (DESYNC).
module seq_reco_multi #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    seq_reco_multi_if.slave  bus
);
    localparam int   SW       = $clog2(DEPTH + 1) + 1;
    localparam int   DepthI   = int'(DEPTH);
    localparam logic ModeSync = 1'b0;

    logic signed [SW-1:0] s_q [NCH];
    logic signed [SW-1:0] s_d [NCH];
    logic                 mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 idle_q, idle_d;
    logic [NCH-1:0]       x_reco_q, x_reco_d;
    logic [NCH-1:0]       y_reco_q, y_reco_d;

    // Returns {next s, xo, yo}. s>0 means x owes s ones, s<0 means y owes -s ones.
    function automatic logic [SW+1:0] lane_next(input logic desync, input logic fl,
                                                input logic xi, input logic yi,
                                                input logic signed [SW-1:0] s);
        int   sv;
        logic hold;
        logic xo;
        logic yo;
        sv   = int'(s);
        hold = !fl && (sv < DepthI) && (sv > -DepthI);
        xo   = xi;
        yo   = yi;
        if (!desync) begin
            unique case ({xi, yi})
                2'b11: ;
                2'b00: begin
                    if (fl && sv > 0) begin xo = 1'b1; sv--; end
                    else if (fl && sv < 0) begin yo = 1'b1; sv++; end
                end
                2'b10: begin
                    if (sv < 0) begin yo = 1'b1; sv++; end
                    else if (hold) begin xo = 1'b0; sv++; end
                end
                2'b01: begin
                    if (sv > 0) begin xo = 1'b1; sv--; end
                    else if (hold) begin yo = 1'b0; sv--; end
                end
            endcase
        end else begin
            unique case ({xi, yi})
                2'b11: if (hold) begin xo = 1'b0; sv++; end
                2'b00: if (sv > 0) begin xo = 1'b1; sv--; end
                2'b10: ;
                2'b01: if (fl && sv > 0) begin xo = 1'b1; sv--; end
            endcase
        end
        return {SW'(sv), xo, yo};
    endfunction

    always_comb begin
        s_d         = s_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        x_reco_d    = '0;
        y_reco_d    = '0;
        if (bus.clr) begin
            for (int i = 0; i < NCH; i++) s_d[i] = '0;
            mode_d = bus.mode;
        end else if (bus.in_valid) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                {s_d[i], x_reco_d[i], y_reco_d[i]} =
                    lane_next(mode_q != ModeSync, bus.flush, bus.x[i], bus.y[i], s_q[i]);
            end
        end
        idle_d = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (s_d[i] != '0) idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) s_q[i] <= '0;
            mode_q      <= ModeSync;
            out_valid_q <= 1'b0;
            idle_q      <= 1'b1;
            x_reco_q    <= '0;
            y_reco_q    <= '0;
        end else begin
            s_q         <= s_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            idle_q      <= idle_d;
            x_reco_q    <= x_reco_d;
            y_reco_q    <= y_reco_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.idle      = idle_q;
    assign bus.x_reco_r  = x_reco_q;
    assign bus.y_reco_r  = y_reco_q;
endmodule

// File: tb/tb_seq_reco_multi.sv
// Bench for seq_reco_multi: three depths (1,2,4) share one stimulus stream and are checked each
// cycle against a held-ones model, plus hand-computed sequences and an async reset probe.
module tb_seq_reco_multi;
    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0, mode = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [NCH-1:0] x = '0, y = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_reco_multi_if #(.NCH(NCH)) if_d1 ();
    seq_reco_multi_if #(.NCH(NCH)) if_d2 ();
    seq_reco_multi_if #(.NCH(NCH)) if_d4 ();

    assign {if_d1.clr, if_d1.mode, if_d1.in_valid, if_d1.flush, if_d1.x, if_d1.y} =
           {clr, mode, in_valid, flush, x, y};
    assign {if_d2.clr, if_d2.mode, if_d2.in_valid, if_d2.flush, if_d2.x, if_d2.y} =
           {clr, mode, in_valid, flush, x, y};
    assign {if_d4.clr, if_d4.mode, if_d4.in_valid, if_d4.flush, if_d4.x, if_d4.y} =
           {clr, mode, in_valid, flush, x, y};

    seq_reco_multi #(.NCH(NCH), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if_d1));
    seq_reco_multi #(.NCH(NCH), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if_d2));
    seq_reco_multi #(.NCH(NCH), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if_d4));

    function automatic int depth_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic int max0(input int v);
        return (v > 0) ? v : 0;
    endfunction

    // {out_valid, idle, y_reco_r, x_reco_r}
    function automatic logic [5:0] dut_obs(input int k);
        case (k)
            0:       return {if_d1.out_valid, if_d1.idle, if_d1.y_reco_r, if_d1.x_reco_r};
            1:       return {if_d2.out_valid, if_d2.idle, if_d2.y_reco_r, if_d2.x_reco_r};
            default: return {if_d4.out_valid, if_d4.idle, if_d4.y_reco_r, if_d4.x_reco_r};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference lane: s counts held ones (x held if positive, y held if negative).
    // An unpaired 1 first cancels a held 1 of the other stream, else is held if there is room.
    function automatic void lane_model(input int depth, input bit desync, input bit fl,
                                       input bit xi, input bit yi, inout int s,
                                       output bit xo, output bit yo);
        bit room;
        room = !fl && (s < depth) && (s > -depth);
        xo = xi;
        yo = yi;
        if (!desync) begin
            if (xi && !yi) begin
                if (s < 0) begin yo = 1; s++; end
                else if (room) begin xo = 0; s++; end
            end else if (!xi && yi) begin
                if (s > 0) begin xo = 1; s--; end
                else if (room) begin yo = 0; s--; end
            end else if (!xi && !yi && fl) begin
                if (s > 0) begin xo = 1; s--; end
                else if (s < 0) begin yo = 1; s++; end
            end
        end else begin
            // Pairs are split by delaying x; the delayed 1 lands on an empty slot.
            if (xi && yi && room) begin xo = 0; s++; end
            else if (!xi && !yi && s > 0) begin xo = 1; s--; end
            else if (!xi && yi && fl && s > 0) begin xo = 1; s--; end
        end
    endfunction

    int             sm [3][NCH] = '{default: 0};
    bit             mode_m = 1'b0;
    logic [5:0]     exp_obs [3] = '{default: 6'b010000};
    int             epoch = 0;
    int             in_x [NCH] = '{default: 0};
    int             in_y [NCH] = '{default: 0};
    bit             m_xo, m_yo;
    logic [NCH-1:0] m_xv, m_yv;
    bit             m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            mode_m = (!rst_n) ? 1'b0 : mode;
            for (int d = 0; d < 3; d++) begin
                for (int l = 0; l < NCH; l++) sm[d][l] = 0;
                exp_obs[d] = 6'b010000;
            end
            for (int l = 0; l < NCH; l++) begin in_x[l] = 0; in_y[l] = 0; end
            epoch++;
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_xv = '0;
                m_yv = '0;
                if (in_valid) begin
                    for (int l = 0; l < NCH; l++) begin
                        lane_model(depth_of(d), mode_m, flush, x[l], y[l], sm[d][l], m_xo, m_yo);
                        m_xv[l] = m_xo;
                        m_yv[l] = m_yo;
                    end
                end
                m_idle = 1'b1;
                for (int l = 0; l < NCH; l++) if (sm[d][l] != 0) m_idle = 1'b0;
                exp_obs[d] = {in_valid, m_idle, m_yv, m_xv};
            end
            if (in_valid) begin
                for (int l = 0; l < NCH; l++) begin
                    in_x[l] += int'(x[l]);
                    in_y[l] += int'(y[l]);
                end
            end
        end
    end

    int seen_epoch = -1;
    int out_x [NCH] = '{default: 0};
    int out_y [NCH] = '{default: 0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("obs_depth%0d", depth_of(k)), 32'(dut_obs(k)), 32'(exp_obs[k]));
        end
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            for (int l = 0; l < NCH; l++) begin out_x[l] = 0; out_y[l] = 0; end
        end
        if (if_d2.out_valid) begin
            for (int l = 0; l < NCH; l++) begin
                out_x[l] += int'(if_d2.x_reco_r[l]);
                out_y[l] += int'(if_d2.y_reco_r[l]);
            end
        end
        for (int l = 0; l < NCH; l++) begin
            check($sformatf("conserve_x_lane%0d", l), 32'(out_x[l] + max0(sm[1][l])), 32'(in_x[l]));
            check($sformatf("conserve_y_lane%0d", l), 32'(out_y[l] + max0(-sm[1][l])), 32'(in_y[l]));
        end
    end

    // Called at a falling edge; returns at the falling edge after the inputs were sampled.
    task automatic step(input bit c, input bit md, input bit v, input bit fl,
                        input logic [NCH-1:0] xv, input logic [NCH-1:0] yv);
        clr = c; mode = md; in_valid = v; flush = fl; x = xv; y = yv;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Literal check of lane 0 of instance k: {idle, y0, x0}
    task automatic lit(input string name, input int k, input logic [2:0] exp);
        logic [5:0] o;
        o = dut_obs(k);
        check(name, 32'({o[4], o[2], o[0]}), 32'(exp));
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk);

        // DEPTH=1 SYNC: hold one x, then pair it with the y
        step(1, 0, 0, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d1_sync_hold", 0, 3'b000);
        step(0, 0, 1, 0, 2'b00, 2'b11); lit("d1_sync_pair", 0, 3'b111);

        // DEPTH=2 SYNC: saturation passes the third x, then two y pair up
        step(1, 0, 0, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d2_sync_1", 1, 3'b000);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d2_sync_2", 1, 3'b000);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d2_sync_sat", 1, 3'b001);
        step(0, 0, 1, 0, 2'b00, 2'b11); lit("d2_sync_4", 1, 3'b011);
        step(0, 0, 1, 0, 2'b00, 2'b11); lit("d2_sync_5", 1, 3'b111);

        // DEPTH=4 SYNC: hold three x, flush them out on empty slots
        step(1, 0, 0, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d4_hold_1", 2, 3'b000);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d4_hold_2", 2, 3'b000);
        step(0, 0, 1, 0, 2'b11, 2'b00); lit("d4_hold_3", 2, 3'b000);
        step(0, 0, 1, 1, 2'b00, 2'b00); lit("d4_flush_1", 2, 3'b001);
        step(0, 0, 1, 1, 2'b00, 2'b00); lit("d4_flush_2", 2, 3'b001);
        step(0, 0, 1, 1, 2'b00, 2'b00); lit("d4_flush_3", 2, 3'b101);

        // DEPTH=2 DESYNC
        step(1, 1, 0, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b11, 2'b11); lit("d2_desync_1", 1, 3'b010);
        step(0, 0, 1, 0, 2'b11, 2'b11); lit("d2_desync_2", 1, 3'b010);
        step(0, 0, 1, 0, 2'b11, 2'b11); lit("d2_desync_sat", 1, 3'b011);
        step(0, 0, 1, 0, 2'b00, 2'b00); lit("d2_desync_4", 1, 3'b001);
        step(0, 0, 1, 0, 2'b00, 2'b00); lit("d2_desync_5", 1, 3'b101);

        // Async reset with a held 1 in every lane
        step(1, 0, 0, 0, 2'b00, 2'b00);
        step(0, 0, 1, 0, 2'b11, 2'b00);
        check("pre_reset_obs", 32'(dut_obs(1)), 32'(6'b100000));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_obs", 32'(dut_obs(1)), 32'(6'b010000));
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Random runs: stalls, sporadic flush, tail flush, mode wiggles without clr
        for (int run = 0; run < 4; run++) begin
            int px, py;
            logic [NCH-1:0] xv, yv;
            px = $urandom_range(1, 9);
            py = $urandom_range(1, 9);
            step(1, 1'($urandom_range(0, 1)), 0, 0, 2'b00, 2'b00);
            for (int i = 0; i < 256; i++) begin
                for (int l = 0; l < NCH; l++) begin
                    xv[l] = ($urandom_range(0, 9) < px);
                    yv[l] = ($urandom_range(0, 9) < py);
                end
                step(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 9) == 0) || (i >= 240), xv, yv);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
